regfile_write_arbiter: RTL and testbench

//  Shares the single write port of the 32x32 register file among NUM_REQ writeback sources
//  (ALU, load unit, multiplier, ...) using round-robin arbitration and a valid/ready handshake.

---
 rtl/regfile_write_arbiter_pkg.sv | 10 +
 rtl/regfile_write_arbiter_rr.sv | 26 ++
 rtl/regfile_write_arbiter.sv | 55 +++++
 tb/tb_regfile_write_arbiter.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/regfile_write_arbiter_pkg.sv
// regfile_write_arbiter_pkg: register file geometry shared by the write arbiter and the register file.
package regfile_write_arbiter_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int NUM_REGS = 32;
    localparam int GID_W = 3;
    function automatic int next_idx(input int i, input int n);
        return (i + 1) % n;
    endfunction
endpackage

// File: rtl/regfile_write_arbiter_rr.sv
// rr_arbiter: round-robin grant over req starting at ptr; ptr moves past the winner on advance.
module rr_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               advance,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic [GID_W-1:0]   grant_idx
);
    localparam int PTR_W = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
    logic [PTR_W-1:0] ptr;
    // Scan from farthest to nearest so the requester closest to ptr is written last and wins.
    always_comb begin
        grant_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--)
            if (req[(int'(ptr) + k) % NUM_REQ]) grant_idx = GID_W'((int'(ptr) + k) % NUM_REQ);
        grant = (!reset && |req) ? NUM_REQ'(1) << grant_idx : '0;
    end
    always_ff @(posedge clock)
        if (reset) ptr <= '0;
        else if (advance) ptr <= PTR_W'(next_idx(int'(grant_idx), NUM_REQ));
endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares the register file write port among NUM_REQ sources, one registered write per cycle.
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter bit ZERO_REG_RO = 1'b1,
    parameter int CNT_W       = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          stall,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*REG_ADDR_W-1:0] req_reg_no,
    input  logic [NUM_REQ*REG_DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          reg_write,
    output logic [REG_ADDR_W-1:0]         write_reg_no,
    output logic [REG_DATA_W-1:0]         write_data,
    output logic [GID_W-1:0]              grant_id,
    output logic [CNT_W-1:0]              write_count
);
    logic [GID_W-1:0] gidx;
    logic [REG_ADDR_W-1:0] sel_reg_no;
    logic [REG_DATA_W-1:0] sel_data;
    logic granted, do_write;
    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clock(clock),
        .reset(reset),
        .advance(granted),
        .req(req_valid & {NUM_REQ{~stall}}),
        .grant(req_ready),
        .grant_idx(gidx)
    );
    assign granted = |req_ready;
    assign sel_reg_no = req_reg_no[int'(gidx)*REG_ADDR_W +: REG_ADDR_W];
    assign sel_data = req_data[int'(gidx)*REG_DATA_W +: REG_DATA_W];
    // A write to r0 still completes the handshake; only the register file enable is withheld.
    assign do_write = granted && !(ZERO_REG_RO && sel_reg_no == '0);
    always_ff @(posedge clock)
        if (reset) begin
            reg_write <= 1'b0;
            write_reg_no <= '0;
            write_data <= '0;
            grant_id <= '0;
            write_count <= '0;
        end else begin
            reg_write <= do_write;
            if (granted) begin
                write_reg_no <= sel_reg_no;
                write_data <= sel_data;
                grant_id <= gidx;
            end
            write_count <= write_count + CNT_W'(do_write);
        end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed stimulus, a request-level model with register file,
// and a per-cycle compare against that model plus literal expectations.
module tb_regfile_write_arbiter;
    logic clock = 1'b0;
    logic reset, stall;
    logic [3:0] req_valid;
    logic [19:0] req_reg_no;
    logic [127:0] req_data;
    logic [3:0] req_ready;
    logic reg_write;
    logic [4:0] write_reg_no;
    logic [31:0] write_data;
    logic [2:0] grant_id;
    logic [15:0] write_count;
    logic [4:0] read_reg1 = '0;
    logic [31:0] rf [32];
    logic [31:0] read_data1;
    int errors = 0, checks = 0;

    regfile_write_arbiter #(.NUM_REQ(4), .ZERO_REG_RO(1'b1), .CNT_W(16)) dut (
        .clock(clock), .reset(reset), .stall(stall), .req_valid(req_valid),
        .req_reg_no(req_reg_no), .req_data(req_data), .req_ready(req_ready),
        .reg_write(reg_write), .write_reg_no(write_reg_no), .write_data(write_data),
        .grant_id(grant_id), .write_count(write_count)
    );

    always #5 clock = ~clock;

    // Register file behind the arbiter; it shares reset, so a write pending during reset is lost.
    initial for (int i = 0; i < 32; i++) rf[i] = '0;
    always @(posedge clock) if (!reset && reg_write && write_reg_no != 0) rf[write_reg_no] <= write_data;
    assign read_data1 = rf[read_reg1];

    // Transaction-level model
    int m_ptr = 0, m_gid = 0, m_cnt = 0;
    bit m_we = 0;
    logic [4:0] m_reg_no = '0;
    logic [31:0] m_data = '0;
    logic [31:0] m_rf [32];
    int grants[$];
    initial for (int i = 0; i < 32; i++) m_rf[i] = '0;

    function automatic int model_grant();
        if (reset || stall) return -1;
        for (int k = 0; k < 4; k++) if (req_valid[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
        return -1;
    endfunction

    always @(posedge clock) begin
        int g;
        g = model_grant();
        if (reset) begin
            m_ptr = 0; m_we = 0; m_reg_no = '0; m_data = '0; m_gid = 0; m_cnt = 0;
        end else begin
            if (m_we) m_rf[m_reg_no] = m_data;
            m_we = 0;
            if (g >= 0) begin
                grants.push_back(g);
                m_reg_no = req_reg_no[g*5 +: 5];
                m_data = req_data[g*32 +: 32];
                m_gid = g;
                m_we = (m_reg_no != 0);
                if (m_we) m_cnt = (m_cnt + 1) % 65536;
                m_ptr = (g + 1) % 4;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        int g;
        g = model_grant();
        chk("req_ready", 32'(req_ready), g < 0 ? 32'd0 : 32'(1) << g);
        chk("reg_write", 32'(reg_write), 32'(m_we));
        chk("write_reg_no", 32'(write_reg_no), 32'(m_reg_no));
        chk("write_data", write_data, m_data);
        chk("grant_id", 32'(grant_id), 32'(m_gid));
        chk("write_count", 32'(write_count), 32'(m_cnt));
        chk("read_data1", read_data1, m_rf[read_reg1]);
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic set_req(input int i, input logic [4:0] r, input logic [31:0] d);
        req_reg_no[i*5 +: 5] = r;
        req_data[i*32 +: 32] = d;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; req_valid = 4'b1111;
        for (int i = 0; i < 4; i++) set_req(i, 5'(i + 1), 32'h1000_0000 + 32'(i));
        tick(); tick();
        #1 chk("t1_ready", 32'(req_ready), 32'h0);
        chk("t1_regwrite", 32'(reg_write), 32'h0);
        chk("t1_count", 32'(write_count), 32'h0);
        // single requester
        reset = 1'b0; req_valid = 4'b0100; set_req(2, 5'd5, 32'hA5A5_0001);
        #1 chk("t2_ready", 32'(req_ready), 32'h4);
        tick(); req_valid = 4'b0000;
        #1 chk("t2_regwrite", 32'(reg_write), 32'h1);
        chk("t2_regno", 32'(write_reg_no), 32'd5);
        chk("t2_gid", 32'(grant_id), 32'd2);
        chk("t2_count", 32'(write_count), 32'd1);
        read_reg1 = 5'd5;
        tick();
        #1 chk("t2_rf5", read_data1, 32'hA5A5_0001);
        // bring ptr back to 0 via req3, then all four contend
        set_req(2, 5'd3, 32'h1000_0002);
        req_valid = 4'b1000;
        tick();
        grants.delete();
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            tick();
            #1 chk("t3_regwrite", 32'(reg_write), 32'h1);
            chk("t3_gid", 32'(grant_id), 32'(k % 4));
        end
        req_valid = 4'b0000;
        chk("t3_count", 32'(write_count), 32'd10);
        chk("t3_ngrants", 32'(grants.size()), 32'd8);
        // stall with req1 pending
        stall = 1'b1; req_valid = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            #1 chk("t4_ready", 32'(req_ready), 32'h0);
            tick();
            #1 chk("t4_regwrite", 32'(reg_write), 32'h0);
        end
        stall = 1'b0;
        #1 chk("t4_release", 32'(req_ready), 32'h2);
        tick(); req_valid = 4'b0000;
        #1 chk("t4_gid", 32'(grant_id), 32'd1);
        // write to r0 is accepted but suppressed
        req_valid = 4'b0001; set_req(0, 5'd0, 32'hFFFF_FFFF);
        #1 chk("t5_ready", 32'(req_ready), 32'h1);
        tick(); req_valid = 4'b0000; read_reg1 = 5'd0;
        #1 chk("t5_regwrite", 32'(reg_write), 32'h0);
        chk("t5_data", write_data, 32'hFFFF_FFFF);
        chk("t5_count", 32'(write_count), 32'd11);
        chk("t5_rf0", read_data1, 32'h0);
        req_valid = 4'b1111;
        #1 chk("t5_ptr1", 32'(req_ready), 32'h2);
        req_valid = 4'b0000;
        // reset while the req3 write is pending in the output register
        req_valid = 4'b1000; set_req(3, 5'd9, 32'hDEAD_BEEF);
        #1 chk("t6_ready", 32'(req_ready), 32'h8);
        tick(); reset = 1'b1; req_valid = 4'b1001;
        #1 chk("t6_ready_rst", 32'(req_ready), 32'h0);
        chk("t6_pending", 32'(reg_write), 32'h1);
        tick(); reset = 1'b0; read_reg1 = 5'd9;
        #1 chk("t6_regwrite", 32'(reg_write), 32'h0);
        chk("t6_count", 32'(write_count), 32'h0);
        chk("t6_rf9", read_data1, 32'h0);
        chk("t6_ready_after", 32'(req_ready), 32'h1);
        tick(); req_valid = 4'b0000;
        #1 chk("t6_gid", 32'(grant_id), 32'd0);
        tick(); tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
